// File: rtl/mpc_pkg.sv
// Shared constants for the mpc sequencer: datapath widths, instruction fields
// and sequencer state encoding.
package mpc_pkg;

    localparam int IW    = 18;
    localparam int OW    = 9;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam int OP_HI = 17;
    localparam int OP_LO = 16;
    localparam int A_HI  = 15;
    localparam int A_LO  = 8;
    localparam int B_HI  = 7;
    localparam int B_LO  = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Index of the final instruction for a requested length; lengths past
    // DEPTH clamp so a run never wraps the program counter.
    function automatic logic [AW-1:0] last_index(input logic [AW:0] len);
        logic [AW:0] w_eff;
        logic [AW:0] w_last;
        w_eff  = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
        w_last = w_eff - (AW+1)'(1);
        return w_last[AW-1:0];
    endfunction

endpackage

// File: rtl/mpc_seq_if.sv
// Host/datapath bundle for mpc_seq: program load, run control, mpc
// instruction/result pair and the tagged result stream.
interface mpc_seq_if;
    import mpc_pkg::*;

    // Result stream: a result transfers on any rising clk edge where
    // res_valid and res_ready are both 1; res_data/res_idx hold while
    // res_valid=1 and res_ready=0, and res_valid never drops without a transfer.
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [IW-1:0] wr_data;
    logic          start;
    logic [AW:0]   len;
    logic [IW-1:0] instr_out;
    logic [OW-1:0] mpc_out;
    logic          res_valid;
    logic          res_ready;
    logic [OW-1:0] res_data;
    logic [AW-1:0] res_idx;
    logic          busy;
    logic          done;
    logic [AW:0]   carry_cnt;
    logic [1:0]    dbg_state;

    modport slave (
        input  wr_en, wr_addr, wr_data, start, len, mpc_out, res_ready,
        output instr_out, res_valid, res_data, res_idx, busy, done,
               carry_cnt, dbg_state
    );

    modport master (
        output wr_en, wr_addr, wr_data, start, len, mpc_out, res_ready,
        input  instr_out, res_valid, res_data, res_idx, busy, done,
               carry_cnt, dbg_state
    );

endinterface

// File: rtl/mpc_prog_mem.sv
// DEPTH x IW program store: one synchronous write port, one combinational
// read port. Contents survive reset on purpose.
module mpc_prog_mem
    import mpc_pkg::*;
(
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [IW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [IW-1:0] o_rd_data
);

    logic [IW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/mpc_seq.sv
// Sequencer: steps the program memory through an external mpc datapath and
// returns one tagged result per instruction over a valid/ready stream.
module mpc_seq
    import mpc_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    mpc_seq_if.slave bus
);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_last;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_rd_addr;
    logic [IW-1:0] w_rd_data;
    logic [IW-1:0] r_instr;
    logic          r_res_valid;
    logic [OW-1:0] r_res_data;
    logic [AW-1:0] r_res_idx;
    logic          r_busy;
    logic          r_done;
    logic [AW:0]   r_carry;

    logic          w_adv;
    logic          w_at_last;
    logic          w_mem_we;
    logic          w_start_run;
    logic          w_start_empty;
    logic          w_capture;
    logic          w_drain_ack;

    assign w_pc_inc  = r_pc + AW'(1);
    assign w_at_last = (r_pc == r_last);

    mpc_prog_mem u_mem (
        .clk       (clk),
        .i_wr_en   (w_mem_we),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_run)             w_state_nxt = S_RUN;
            S_RUN:   if (w_capture && w_at_last)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_ack)             w_state_nxt = S_IDLE;
            default:                              w_state_nxt = S_IDLE;
        endcase
    end

    // The read port serves mem[0] while idle (run launch) and mem[pc+1]
    // while running, so the next instruction is ready at each capture.
    always_comb begin
        w_adv         = !r_res_valid || bus.res_ready;
        w_mem_we      = 1'b0;
        w_start_run   = 1'b0;
        w_start_empty = 1'b0;
        w_capture     = 1'b0;
        w_drain_ack   = 1'b0;
        w_rd_addr     = w_pc_inc;
        case (r_state)
            S_IDLE: begin
                w_mem_we      = bus.wr_en;
                w_start_run   = bus.start && (bus.len != '0);
                w_start_empty = bus.start && (bus.len == '0);
                w_rd_addr     = '0;
            end
            S_RUN:   w_capture   = w_adv;
            S_DRAIN: w_drain_ack = r_res_valid && bus.res_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= '0;
            r_last      <= '0;
            r_instr     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_idx   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_carry     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_start_run) begin
                r_busy  <= 1'b1;
                r_pc    <= '0;
                r_instr <= w_rd_data;
                r_carry <= '0;
                r_last  <= last_index(bus.len);
            end
            if (w_start_empty) begin
                r_done  <= 1'b1;
                r_carry <= '0;
            end
            if (w_capture) begin
                r_res_data  <= bus.mpc_out;
                r_res_idx   <= r_pc;
                r_res_valid <= 1'b1;
                if (bus.mpc_out[OW-1] && (r_carry != '1)) begin
                    r_carry <= r_carry + (AW+1)'(1);
                end
                if (w_at_last) begin
                    r_instr <= '0;
                end else begin
                    r_pc    <= w_pc_inc;
                    r_instr <= w_rd_data;
                end
            end
            if (w_drain_ack) begin
                r_res_valid <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
            end
        end
    end

    assign bus.instr_out = r_instr;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_idx   = r_res_idx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.carry_cnt = r_carry;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mpc_seq.sv
// Bench for mpc_seq with a stand-in mpc datapath beside it; results are
// checked against an expected queue by a separate monitor.
module tb_mpc_seq;
    import mpc_pkg::*;

    logic clk = 1'b0;
    logic reset;

    mpc_seq_if bus ();

    mpc_seq u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational mpc datapath (op 00 is add).
    function automatic logic [OW-1:0] mpc_model(input logic [IW-1:0] ins);
        logic [7:0] a;
        logic [7:0] b;
        a = ins[A_HI:A_LO];
        b = ins[B_HI:B_LO];
        case (ins[OP_HI:OP_LO])
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    assign bus.mpc_out = mpc_model(bus.instr_out);

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    logic [AW+OW-1:0] exp_q[$];
    logic [IW-1:0]    prog[DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per accepted result and counts done pulses.
    initial begin
        logic [AW+OW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.done) done_cnt++;
                if (bus.res_valid && bus.res_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got idx=%0d data=%0d expected none",
                                 bus.res_idx, bus.res_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_idx_data", 32'({bus.res_idx, bus.res_data}), 32'(e));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic [IW-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
        prog[addr]  = data;
    endtask

    task automatic push_run(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({AW'(i), mpc_model(prog[i])});
        end
    endtask

    task automatic start_run(input int n);
        bus.start = 1'b1;
        bus.len   = (AW+1)'(n);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        tick();
        tick();
        check(name, 32'(done_cnt - d0), 32'd1);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int d0;
        int exp_carry;
        reset         = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr_out", 32'(bus.instr_out), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data",  32'(bus.res_data),  32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_carry",     32'(bus.carry_cnt), 32'd0);
        check("rst_state",     32'(bus.dbg_state), 32'(S_IDLE));
        reset = 1'b0;
        tick();

        // Basic run with hand-computed sums 77+47 and 205+239.
        write_word(0, 18'b00_01001101_00101111);
        write_word(1, 18'b00_11001101_11101111);
        bus.res_ready = 1'b1;
        exp_q.push_back({4'd0, 9'd124});
        exp_q.push_back({4'd1, 9'd444});
        start_run(2);
        wait_done("t1_done", 20);
        check("t1_carry", 32'(bus.carry_cnt), 32'd1);
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // Backpressure: hold the first result for three cycles.
        bus.res_ready = 1'b0;
        exp_q.push_back({4'd0, 9'd124});
        exp_q.push_back({4'd1, 9'd444});
        start_run(2);
        k = 0;
        while (!bus.res_valid && k < 10) begin
            tick();
            k++;
        end
        check("t2_first_valid", 32'(bus.res_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
            check("t2_hold_data",  32'(bus.res_data),  32'd124);
            check("t2_hold_idx",   32'(bus.res_idx),   32'd0);
            check("t2_hold_instr", 32'(bus.instr_out), 32'(18'b00_11001101_11101111));
            tick();
        end
        bus.res_ready = 1'b1;
        wait_done("t2_done", 20);
        check("t2_carry", 32'(bus.carry_cnt), 32'd1);
        check("t2_queue", 32'(exp_q.size()), 32'd0);

        // len=0: immediate done, no result.
        start_run(0);
        check("t3_len0_done",  32'(bus.done),      32'd1);
        check("t3_len0_valid", 32'(bus.res_valid), 32'd0);
        check("t3_len0_busy",  32'(bus.busy),      32'd0);
        tick();
        check("t3_len0_pulse", 32'(bus.done), 32'd0);

        // len=20 clamps to 16 results.
        exp_carry = 0;
        for (int i = 0; i < DEPTH; i++) begin
            write_word(i, {2'b00, 8'(i * 17), 8'(i * 13 + 5)});
            if (mpc_model(prog[i]) >= 9'd256) exp_carry++;
        end
        push_run(DEPTH);
        start_run(20);
        wait_done("t3_len20_done", 60);
        check("t3_len20_carry", 32'(bus.carry_cnt), 32'(exp_carry));
        check("t3_len20_queue", 32'(exp_q.size()), 32'd0);

        // Write and start while busy are dropped.
        push_run(4);
        start_run(4);
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = {2'b00, 8'hAA, 8'h55};
        bus.start   = 1'b1;
        bus.len     = (AW+1)'(1);
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        check("t4_busy_during", 32'(bus.busy), 32'd1);
        wait_done("t4_done", 30);
        check("t4_queue", 32'(exp_q.size()), 32'd0);
        push_run(1);
        start_run(1);
        wait_done("t4_rerun_done", 20);
        check("t4_rerun_queue", 32'(exp_q.size()), 32'd0);

        // Reset after two of four results.
        push_run(2);
        start_run(4);
        tick();
        tick();
        @(negedge clk);
        #1;
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check("t5_rst_instr", 32'(bus.instr_out), 32'd0);
        check("t5_rst_valid", 32'(bus.res_valid), 32'd0);
        check("t5_rst_idx",   32'(bus.res_idx),   32'd0);
        check("t5_rst_data",  32'(bus.res_data),  32'd0);
        check("t5_rst_busy",  32'(bus.busy),      32'd0);
        check("t5_rst_carry", 32'(bus.carry_cnt), 32'd0);
        check("t5_rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        check("t5_queue", 32'(exp_q.size()), 32'd0);
        push_run(4);
        start_run(4);
        wait_done("t5_rerun_done", 30);
        check("t5_rerun_queue", 32'(exp_q.size()), 32'd0);

        // Every word carries: count must reach 16, not wrap.
        for (int i = 0; i < DEPTH; i++) begin
            write_word(i, {2'b00, 8'(192 + i), 8'h50});
        end
        push_run(DEPTH);
        start_run(DEPTH);
        wait_done("t6_done", 60);
        check("t6_carry", 32'(bus.carry_cnt), 32'd16);
        check("t6_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
